// File: rtl/mul_div_unit.sv
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
//             Optional macro MULDIV_EARLY_EXIT_EN: multiply leaves CALC
//             once the remaining multiplier bits are all zero.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] c_last_iter = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic               negr_q, negr_d;
    logic               dz_q, dz_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_quo, w_rem;
    logic [2*WIDTH-1:0] w_prod;

    // op[0]=0 selects the signed variants (MULT, DIV)
    assign w_a_neg = ~op[0] & srca[WIDTH-1];
    assign w_b_neg = ~op[0] & srcb[WIDTH-1];
    assign w_a_mag = w_a_neg ? -srca : srca;
    assign w_b_mag = w_b_neg ? -srcb : srcb;

    // Divide: acc holds {rem, quo}; the trial uses the bit shifted out of rem
    assign w_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, mcand_q[WIDTH-1:0]};
    assign w_quo  = acc_q[WIDTH-1:0];
    assign w_rem  = acc_q[2*WIDTH-1:WIDTH];
    assign w_prod = neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        dz_d     = dz_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d     = op;
                    neg_d    = w_a_neg ^ w_b_neg;
                    negr_d   = w_a_neg;
                    cnt_d    = '0;
                    mplier_d = w_b_mag;
                    dz_d     = 1'b0;
                    state_d  = S_CALC;
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, w_a_mag};
                        mcand_d = {{WIDTH{1'b0}}, w_b_mag};
                        if (srcb == '0) begin
                            // Raw dividend parks in the rem half for HI
                            dz_d    = 1'b1;
                            acc_d   = {srca, {WIDTH{1'b0}}};
                            state_d = S_FIX;
                        end
                    end else begin
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, w_a_mag};
`ifdef MULDIV_EARLY_EXIT_EN
                        if (w_b_mag == '0)
                            state_d = S_FIX;
`endif
                    end
                end else begin
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end

            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[1]) begin
                    if (!w_diff[WIDTH])
                        acc_d = {w_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end else begin
                    if (mplier_q[0])
                        acc_d = acc_q + mcand_q;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                end
                if (cnt_q == c_last_iter)
                    state_d = S_FIX;
`ifdef MULDIV_EARLY_EXIT_EN
                if (!op_q[1] && ((mplier_q >> 1) == '0))
                    state_d = S_FIX;
`endif
            end

            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                cnt_d   = '0;
                if (dz_q) begin
                    hi_d = w_rem;
                    lo_d = '1;
                end else if (op_q[1]) begin
                    hi_d = negr_q ? -w_rem : w_rem;
                    lo_d = neg_q ? -w_quo : w_quo;
                end else begin
                    {hi_d, lo_d} = w_prod;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            dz_q     <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            dz_q     <= dz_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Scoreboard bench for mul_div_unit against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mul_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] srca, srcb, wdata;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    mul_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           e0;
        int           lat;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {hi, lo} from plain arithmetic
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, sp, sq, sr;
        logic [63:0]        ua, ub;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            2'b00: begin sp = sa * sb; return sp; end
            2'b01: return ua * ub;
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Edges from start to done (= cycles busy is high)
    function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
        logic [31:0] mag;
        if (o[1] && b == 32'd0) return 1;
        mag = (!o[0] && b[31]) ? -b : b;
`ifdef MULDIV_EARLY_EXIT_EN
        if (!o[1]) begin
            if (mag == 32'd0) return 1;
            for (int i = 31; i >= 0; i--)
                if (mag[i]) return i + 2;
        end
`else
        if (mag == 32'hDEAD_0000) return W + 1;
`endif
        return W + 1;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding operation
    always @(negedge clk) begin
        if (reset === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 at cycle %0d, expected no pulse", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("result_hi", hi, mon_e.hi);
                check("result_lo", lo, mon_e.lo);
                check("latency", cyc - mon_e.e0, mon_e.lat);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            tick();
            k++;
        end
        if (busy) check("idle_timeout", busy, 1'b0);
    endtask

    // Drive start for one edge and push the expected response
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [63:0] r;
        r     = model(o, a, b);
        e.hi  = r[63:32];
        e.lo  = r[31:0];
        e.e0  = cyc + 1;
        e.lat = model_lat(o, b);
        sb_q.push_back(e);
        op    = o;
        srca  = a;
        srcb  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        wait_idle();
        issue(o, a, b);
        while (busy && n < 200) begin
            n++;
            tick();
        end
        check("busy_cycles", n, model_lat(o, b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = 2'b00; srca = '0; srcb = '0; wdata = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        run_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg3x7_hi", hi, 32'hFFFF_FFFF);
        check("mult_neg3x7_lo", lo, 32'hFFFF_FFEB);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
`ifdef MULDIV_EARLY_EXIT_EN
        run_op(2'b01, 32'd5, 32'd2);
        check("early_5x2_lo", lo, 32'd10);
        run_op(2'b01, 32'd77, 32'd0);
        check("early_x0_lo", lo, 32'd0);
`endif
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        check("div_neg7_2_lo", lo, 32'hFFFF_FFFD);
        check("div_neg7_2_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd7, 32'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);
        run_op(2'b11, 32'h1234, 32'd0);
        check("divz_hi", hi, 32'h1234);
        check("divz_lo", lo, 32'hFFFF_FFFF);

        // start and mthi while busy must both be ignored
        wait_idle();
        issue(2'b00, 32'd3, 32'd4);
        repeat (4) tick();
        op = 2'b11; srca = 32'd9; srcb = 32'd3; wdata = 32'hAAAA;
        start = 1'b1; mthi = 1'b1;
        tick();
        start = 1'b0; mthi = 1'b0;
        check("hi_hold_busy", hi, 32'h1234);
        wait_idle();
        tick(); tick();
        check("no_relaunch", busy, 1'b0);
        check("mult3x4_lo", lo, 32'd12);

        wdata = 32'h55; mtlo = 1'b1;
        tick();
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h55);
        check("mtlo_hi", hi, 32'h0);
        wdata = 32'h1357; mthi = 1'b1; mtlo = 1'b1;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("mthilo_hi", hi, 32'h1357);
        check("mthilo_lo", lo, 32'h1357);

        // start wins over mthi in the same idle cycle
        wdata = 32'hDEAD; mthi = 1'b1;
        issue(2'b01, 32'd2, 32'd3);
        mthi = 1'b0;
        check("start_wins_hi", hi, 32'h1357);
        check("start_wins_lo", lo, 32'h1357);
        wait_idle();
        tick();

        // Asynchronous reset in the middle of a divide
        op = 2'b10; srca = 32'hFFFF_FFCE; srcb = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #2 reset = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_hi", hi, 32'h0);
        check("async_rst_lo", lo, 32'h0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        run_op(2'b11, 32'd100, 32'd7);
        check("post_rst_lo", lo, 32'd14);
        check("post_rst_hi", hi, 32'd2);

        // Randomized operations, back to back
        for (int i = 0; i < 30; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            int          sel;
            ro  = 2'($urandom_range(0, 3));
            ra  = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      rb = 32'd0;
            else if (sel < 3)  rb = 32'($urandom_range(1, 20));
            else if (sel == 3) rb = -32'($urandom_range(1, 20));
            else               rb = $urandom;
            run_op(ro, ra, rb);
        end

        begin
            int k = 0;
            while (sb_q.size() > 0 && k < 100) begin
                tick();
                k++;
            end
            if (sb_q.size() > 0) check("pending_results", sb_q.size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, next to the ALU in the execute stage.
- Consumes register-file operands srca/srcb; hi/lo feed the result mux for MFHI/MFLO.
- Executes MULT, MULTU, DIV, DIVU in WIDTH iterations using a start/busy/done handshake, and supports MTHI/MTLO writes.
- Controller stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count = WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  launch operation; sampled only when idle.
- op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- srca  input  WIDTH  multiplicand / dividend.
- srcb  input  WIDTH  multiplier / divisor.
- mthi  input  1  write wdata to hi; idle only.
- mtlo  input  1  write wdata to lo; idle only.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse, registered; hi/lo are valid in the same cycle.
- hi  output  WIDTH  product high word / remainder.
- lo  output  WIDTH  product low word / quotient.

Behaviour:
- Reset (async, any time, including mid-operation): state=IDLE, busy=0, done=0, hi=0, lo=0, iteration counter=0. Operation in flight is discarded.
- States:
  - IDLE -> CALC on start.
  - CALC runs WIDTH edges, then -> FIX.
  - FIX -> IDLE.
  - busy = (state != IDLE). done is registered high only on the FIX->IDLE edge.
- Start edge E0:
  - Latch op and operand magnitudes. For signed ops, negate negative operands (two's complement).
  - Record result signs:
    - product sign = sa^sb
    - quotient sign = sa^sb
    - remainder sign = sa
  - Unsigned ops treat operands as-is.
- Multiply (shift-add):
  - Registers: 2*WIDTH accumulator, 2*WIDTH multiplicand shifted left 1 per edge, multiplier shifted right 1 per edge.
  - Add the multiplicand to the accumulator when the multiplier LSB = 1.
- Divide (restoring):
  - Each edge: shift {rem, quo} left 1.
  - Trial-subtract the divisor from rem. If non-negative, keep the difference and set the quotient LSB.
- FIX edge (E33 for WIDTH=32):
  - Apply sign correction.
  - Write {hi,lo} = product, or hi = remainder, lo = quotient.
  - done <= 1.
- Latency: the result is visible and done=1 in the cycle after edge E(WIDTH+1), i.e. 33 edges after start for WIDTH=32. busy is high for exactly WIDTH+1 cycles.
- Divide by zero (DIV/DIVU, srcb=0): detected at E0, state goes directly to FIX. At E1: hi=srca, lo=all ones, done=1. Latency 1.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- start while busy: ignored. Operands and op are not re-sampled.
- start in the done cycle (state IDLE): accepted. Back-to-back operations are allowed.
- mthi/mtlo while busy: ignored.
- mthi/mtlo together with start in the same idle cycle: start wins; the writes are dropped.
- mthi and mtlo in the same cycle: both registers are written with wdata.
- hi/lo hold their values except on FIX or an MTHI/MTLO write. Accumulator arithmetic wraps modulo 2^(2*WIDTH).

Optional Feature:
- Macro: MULDIV_EARLY_EXIT_EN.
- Defined (multiply only): CALC exits to FIX on the edge where the remaining multiplier register becomes zero. If the multiplier magnitude is 0 at start, go directly to FIX.
  - Latency = msb_index(|srcb|) + 2 edges, or 1 edge for srcb=0.
- Undefined: multiply always takes WIDTH+1 edges. Divide timing is unaffected in both cases.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 33 cycles; single done pulse at edge 33 (macro off).
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
  - With MULDIV_EARLY_EXIT_EN: MULTU 5*2 -> lo=10 after 3 edges.
  - With MULDIV_EARLY_EXIT_EN: srcb=0 -> lo=0 after 1 edge.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIVU 7/2 -> lo=3, hi=1.
  - DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 0x1234/0 -> hi=0x00001234, lo=0xFFFFFFFF; done one edge after start; busy high 1 cycle.
- Start MULT 3*4, then at cycle 5 assert start (DIVU 9/3) and mthi wdata=0xAAAA -> both ignored, final lo=12, hi=0.
  - Then in the idle cycle: mtlo wdata=0x55 -> lo=0x55.
- Start DIV, assert reset at cycle 10 for 1 cycle -> busy=0, done=0, hi=lo=0 immediately (asynchronous).
  - No done pulse follows; a new DIVU 100/7 then yields lo=14, hi=2.
